// File: rtl/capture_readout_if.sv
// rtl/capture_readout_if.sv - outgoing byte stream handshake of the capture readout
interface capture_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - post-trigger capture control and sample buffer dump (optional header via READOUT_HEADER_EN)
module capture_readout #(
    parameter int AW  = 10,
    parameter int PRE = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [AW-1:0] wptr_at_trig,
    output logic          cap_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    input  logic          rearm,
    output logic          busy,
    output logic          done,
    capture_readout_if.master tx
);

    localparam int            DEPTH  = 1 << AW;
    localparam logic [AW-1:0] PRE_A  = AW'(PRE);
    localparam logic [AW:0]   POST_N = (AW+1)'(DEPTH - PRE);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

    // S_HDR is only entered when the header option is compiled in.
    typedef enum logic [2:0] {
        S_CAPTURE,
        S_POST,
        S_HDR,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW:0]   post_cnt;
    logic [AW-1:0] byte_cnt;
    logic [AW-1:0] start;
    logic          rd_phase;   // 0: address just presented, 1: rd_data now valid
    logic          hdr_idx;    // which header byte is on the bus

    // Capture/readout sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CAPTURE;
            cap_en      <= 1'b1;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
            rd_addr     <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            post_cnt    <= '0;
            byte_cnt    <= '0;
            start       <= '0;
            rd_phase    <= 1'b0;
            hdr_idx     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_CAPTURE: begin
                    if (trig) begin
                        start    <= wptr_at_trig - PRE_A;
                        post_cnt <= POST_N;
                        state    <= S_POST;
                    end
                end
                S_POST: begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == (AW+1)'(1)) begin
                        cap_en   <= 1'b0;
                        rd_addr  <= start;
                        byte_cnt <= '0;
                        rd_phase <= 1'b0;
`ifdef READOUT_HEADER_EN
                        tx.tx_data  <= 8'hA5;
                        tx.tx_valid <= 1'b1;
                        hdr_idx     <= 1'b0;
                        state       <= S_HDR;
`else
                        state       <= S_READ;
`endif
                    end
                end
                S_HDR: begin
                    // tx_valid is held high for both header bytes.
                    if (tx.tx_ready) begin
                        if (!hdr_idx) begin
                            tx.tx_data <= 8'h5A;
                            hdr_idx    <= 1'b1;
                        end else begin
                            tx.tx_valid <= 1'b0;
                            state       <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // Wait one cycle for the synchronous RAM before loading.
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        tx.tx_data  <= rd_data;
                        tx.tx_valid <= 1'b1;
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx.tx_ready) begin
                        tx.tx_valid <= 1'b0;
                        rd_addr     <= rd_addr + 1'b1;
                        byte_cnt    <= byte_cnt + 1'b1;
                        rd_phase    <= 1'b0;
                        if (byte_cnt == LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    if (rearm) begin
                        state  <= S_CAPTURE;
                        cap_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                default: state <= S_CAPTURE;
            endcase
        end
    end

endmodule
